// File: rtl/clk_div_bank.sv
// Multi-channel clock divider bank. Every channel has its own runtime-configurable
// divisor and enable. A new setting takes effect only at that channel's period
// boundary, and a shared sync strobe restarts all enabled channels in phase.
module clk_div_bank #(
  parameter int unsigned NCH = 3,
  parameter int unsigned DIV_W = 16,
  parameter logic [NCH*DIV_W-1:0] INIT_DIV = {16'd89, 16'd359, 16'd19},
  parameter logic [NCH-1:0] INIT_EN = 3'b111,
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             sync_i,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);

  localparam int unsigned DW1 = DIV_W + 1;

  logic [DIV_W-1:0] cnt      [NCH];
  logic [DIV_W-1:0] div_act  [NCH];
  logic [DIV_W-1:0] pend_div [NCH];
  logic [NCH-1:0]   en_act;
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   pend_en;

  logic [DIV_W-1:0] cnt_nx [NCH];
  logic [DIV_W-1:0] div_nx [NCH];
  logic [NCH-1:0]   en_nx;
  logic [NCH-1:0]   pend_nx;
  logic [NCH-1:0]   clk_nx;
  logic [NCH-1:0]   tick_nx;
  logic [NCH-1:0]   take;
  logic [NCH-1:0]   wrap;
  logic [NCH-1:0]   apply;
  logic [NCH-1:0]   restart;

  // A divisor of 0 (N=1) is illegal and is forced to 1 (N=2).
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  // High time H = N>>1, computed one bit wider so that N = 2^DIV_W cannot overflow.
  function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] d);
    return ({1'b0, d} + DW1'(1)) >> 1;
  endfunction

  // Config slot lookup for the addressed channel. An out-of-range channel is never ready.
  always_comb begin
    cfg_ready = 1'b0;
    take      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pend[i];
        take[i]   = cfg_valid && !pend[i];
      end
    end
  end

  // Per-channel next state: wrap/sync/idle apply of pending config, then count or restart.
  always_comb begin
    wrap    = '0;
    apply   = '0;
    restart = '0;
    en_nx   = en_act;
    pend_nx = pend;
    clk_nx  = '0;
    tick_nx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_nx[i]  = '0;
      wrap[i]    = en_act[i] && (cnt[i] == div_act[i]);
      apply[i]   = pend[i] && (wrap[i] || sync_i || !en_act[i]);
      div_nx[i]  = apply[i] ? pend_div[i] : div_act[i];
      en_nx[i]   = apply[i] ? pend_en[i] : en_act[i];
      restart[i] = en_nx[i] && (wrap[i] || sync_i || !en_act[i]);
      pend_nx[i] = take[i] || (pend[i] && !apply[i]);
      if (!en_nx[i]) begin
        cnt_nx[i]  = '0;
        clk_nx[i]  = 1'b0;
        tick_nx[i] = 1'b0;
      end else if (restart[i]) begin
        cnt_nx[i]  = '0;
        clk_nx[i]  = 1'b1;
        tick_nx[i] = 1'b1;
      end else begin
        cnt_nx[i]  = cnt[i] + DIV_W'(1);
        clk_nx[i]  = ({1'b0, cnt_nx[i]} < high_len(div_nx[i]));
        tick_nx[i] = 1'b0;
      end
    end
  end

  // State and output registers. Reset preloads cnt=div so that the first edge wraps.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]      <= clamp_div(INIT_DIV[i*DIV_W +: DIV_W]);
        div_act[i]  <= clamp_div(INIT_DIV[i*DIV_W +: DIV_W]);
        pend_div[i] <= '0;
      end
      en_act  <= INIT_EN;
      pend    <= '0;
      pend_en <= '0;
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]     <= cnt_nx[i];
        div_act[i] <= div_nx[i];
        if (take[i]) begin
          pend_div[i] <= clamp_div(cfg_div);
          pend_en[i]  <= cfg_en;
        end
      end
      en_act  <= en_nx;
      pend    <= pend_nx;
      clk_out <= clk_nx;
      tick    <= tick_nx;
    end
  end

  assign busy = pend;

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: a time-based reference model (period start time, period
// length, pending request) checked against the DUT on every cycle, plus directed
// scenarios with hand-computed expectations and a randomized config/sync phase.
module tb_clk_div_bank;

  localparam int unsigned NCH   = 3;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned CH_W  = 2;
  localparam logic [NCH*DIV_W-1:0] INIT_DIV = {16'd89, 16'd359, 16'd19};
  localparam logic [NCH-1:0] INIT_EN = 3'b111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic             sync_i;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   busy;

  int errors = 0;
  int checks = 0;

  clk_div_bank #(
    .NCH(NCH), .DIV_W(DIV_W), .INIT_DIV(INIT_DIV), .INIT_EN(INIT_EN)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_en(cfg_en), .sync_i(sync_i),
    .clk_out(clk_out), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: each channel is described by its period length and the cycle in which its current period began.
  int cyc;
  int m_n     [NCH];
  int m_start [NCH];
  int m_pn    [NCH];
  bit m_en    [NCH];
  bit m_pend  [NCH];
  bit m_pen   [NCH];

  function automatic int period_of(input int d);
    return (d == 0) ? 2 : d + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < NCH; i++) begin
        m_n[i]     = period_of(int'(INIT_DIV[i*DIV_W +: DIV_W]));
        m_en[i]    = INIT_EN[i];
        m_pend[i]  = 1'b0;
        m_pen[i]   = 1'b0;
        m_pn[i]    = 2;
        m_start[i] = 1 - m_n[i];
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < NCH; i++) begin
        bit old_pend, old_en, boundary;
        old_pend = m_pend[i];
        old_en   = m_en[i];
        boundary = old_en && ((cyc - m_start[i]) == m_n[i]);
        if (old_pend && (boundary || sync_i || !old_en)) begin
          m_n[i]    = m_pn[i];
          m_en[i]   = m_pen[i];
          m_pend[i] = 1'b0;
        end
        if (m_en[i] && (boundary || sync_i || !old_en))
          m_start[i] = cyc;
        if (cfg_valid && (int'(cfg_ch) == i) && !old_pend) begin
          m_pend[i] = 1'b1;
          m_pn[i]   = period_of(int'(cfg_div));
          m_pen[i]  = cfg_en;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NCH-1:0] ec, et, eb;
    logic er;
    er = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = m_en[i] && ((cyc - m_start[i]) < (m_n[i] / 2));
      et[i] = m_en[i] && (cyc == m_start[i]);
      eb[i] = m_pend[i];
      if (int'(cfg_ch) == i) er = !m_pend[i];
    end
    checks++;
    if ({clk_out, tick, busy, cfg_ready} !== {ec, et, eb, er}) begin
      errors++;
      $display("FAIL model cyc=%0d clk_out=%b want %b tick=%b want %b busy=%b want %b cfg_ready=%b want %b",
               cyc, clk_out, ec, tick, et, busy, eb, cfg_ready, er);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (cyc=%0d)", name, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_cfg(input int ch, input int dv, input bit e);
    bit done;
    done = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
    cfg_en    = e;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      done = cfg_ready;
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    if (!done) timeout("write_cfg");
  endtask

  task automatic wait_tick(input int ch);
    int k;
    k = 0;
    do begin
      step(1);
      k++;
    end while (!tick[ch] && k < 2000);
    if (!tick[ch]) timeout("wait_tick");
  endtask

  task automatic wait_idle(input logic [NCH-1:0] mask);
    int k;
    k = 0;
    while (((busy & mask) != '0) && k < 2000) begin
      step(1);
      k++;
    end
    if ((busy & mask) != '0) timeout("wait_idle");
  endtask

  // Starting on a tick cycle, measure the length and the high time of one period.
  task automatic measure(input int ch, output int len, output int hi);
    len = 0;
    hi  = 0;
    do begin
      hi += int'(clk_out[ch]);
      len++;
      step(1);
    end while (!tick[ch] && len < 1000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1);
  end

  initial begin
    int hi0, hi1, hi2, tk0, tk2, t0, len, hi, bad, c0, c2;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0; sync_i = 1'b0;
    #23;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("first_tick", int'(tick), 7);
    chk("first_clk_out", int'(clk_out), 7);

    // Reset divisors: high/low halves over one full period of each channel.
    hi0 = 0; hi1 = 0; hi2 = 0; tk0 = 0; tk2 = 0;
    for (int k = 0; k < 360; k++) begin
      if (k < 20) hi0 += int'(clk_out[0]);
      if (k < 90) hi2 += int'(clk_out[2]);
      hi1 += int'(clk_out[1]);
      tk0 += int'(tick[0]);
      tk2 += int'(tick[2]);
      step(1);
    end
    chk("ch0_high", hi0, 10);
    chk("ch1_high", hi1, 180);
    chk("ch2_high", hi2, 45);
    chk("ch0_ticks", tk0, 18);
    chk("ch2_ticks", tk2, 4);

    // Odd divisor written mid-period: boundary period keeps its old length.
    chk("odd_tick_at_361", int'(tick[0]), 1);
    t0 = cyc;
    step(7);
    write_cfg(0, 4, 1'b1);
    chk("odd_busy", int'(busy[0]), 1);
    wait_tick(0);
    chk("odd_boundary_len", cyc - t0, 20);
    chk("odd_busy_clear", int'(busy[0]), 0);
    measure(0, len, hi);
    chk("odd_len", len, 5);
    chk("odd_high", hi, 2);
    measure(0, len, hi);
    chk("odd_len2", len, 5);
    chk("odd_high2", hi, 2);

    // Back-pressure on ch1 while ch2 still accepts a write.
    write_cfg(1, 199, 1'b1);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd99; cfg_en = 1'b1;
    #1;
    chk("bp_ch1_ready", int'(cfg_ready), 0);
    cfg_ch = 2'd2; cfg_div = 16'd89;
    #1;
    chk("bp_ch2_ready", int'(cfg_ready), 1);
    step(1);
    cfg_valid = 1'b0;
    chk("bp_busy", int'(busy), 6);
    write_cfg(1, 99, 1'b1);
    chk("bp_second_accept_cyc", cyc, 722);
    chk("bp_second_busy", int'(busy[1]), 1);

    // Disable ch2, then re-enable at divisor 1.
    write_cfg(2, 89, 1'b0);
    wait_idle(3'b100);
    hi = 0; len = 0;
    for (int k = 0; k < 200; k++) begin
      hi  += int'(clk_out[2]);
      len += int'(tick[2]);
      step(1);
    end
    chk("dis_high", hi, 0);
    chk("dis_ticks", len, 0);
    write_cfg(2, 1, 1'b1);
    chk("en_busy", int'(busy[2]), 1);
    chk("en_clk_before", int'(clk_out[2]), 0);
    step(1);
    chk("en_tick", int'(tick[2]), 1);
    chk("en_clk", int'(clk_out[2]), 1);
    chk("en_busy_clear", int'(busy[2]), 0);
    measure(2, len, hi);
    chk("en_len", len, 2);
    chk("en_high", hi, 1);

    // Sync strobe aligns ch0 (N=20) with ch2 (N=80).
    write_cfg(0, 19, 1'b1);
    write_cfg(2, 79, 1'b1);
    wait_idle(3'b101);
    step(int'($urandom_range(1, 60)));
    sync_i = 1'b1;
    step(1);
    sync_i = 1'b0;
    chk("sync_tick", int'(tick), 7);
    c0 = 0; c2 = 0; bad = 0;
    for (int k = 0; k < 400; k++) begin
      c0 += int'(tick[0]);
      c2 += int'(tick[2]);
      if (tick[2] && !tick[0]) bad++;
      step(1);
    end
    chk("sync_ch0_ticks", c0, 20);
    chk("sync_ch2_ticks", c2, 5);
    chk("sync_misaligned", bad, 0);

    // Divisor 0 is clamped to N=2.
    write_cfg(0, 0, 1'b1);
    wait_idle(3'b001);
    wait_tick(0);
    measure(0, len, hi);
    chk("clamp_len", len, 2);
    chk("clamp_high", hi, 1);

    // Asynchronous reset with a pending config.
    wait_idle(3'b010);
    write_cfg(1, 50, 1'b1);
    chk("rst_mid_busy_before", int'(busy[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clk_out", int'(clk_out), 0);
    chk("rst_mid_tick", int'(tick), 0);
    chk("rst_mid_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("rst_mid_first_tick", int'(tick), 7);
    measure(1, len, hi);
    chk("rst_mid_ch1_len", len, 360);
    chk("rst_mid_ch1_high", hi, 180);
    measure(0, len, hi);
    chk("rst_mid_ch0_len", len, 20);
    chk("rst_mid_ch0_high", hi, 10);

    // Randomized config traffic, including out-of-range channels and sync pulses.
    for (int k = 0; k < 20000; k++) begin
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg_div   = ($urandom_range(0, 9) == 0) ? '0 : DIV_W'($urandom_range(1, 40));
      cfg_en    = ($urandom_range(0, 4) != 0);
      sync_i    = ($urandom_range(0, 199) == 0);
      step(1);
    end
    cfg_valid = 1'b0;
    sync_i    = 1'b0;
    step(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
